// File: rtl/reg_select_scoreboard.sv
// Registered register-select decode with a per-register write scoreboard.
// Stalls issue on RAW/WAW hazards; a retire in the same cycle bypasses the hazard.

module reg_select_scoreboard_entry (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  input  logic flush,
  output logic pend
);
  logic pend_d, pend_q;

  // A set and a clear in the same cycle leave the bit set.
  always_comb begin
    pend_d = pend_q;
    if (flush)    pend_d = 1'b0;
    else if (set) pend_d = 1'b1;
    else if (clr) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

  assign pend = pend_q;
endmodule

module reg_select_scoreboard #(
  parameter int          INSTR_W  = 32,
  parameter int          ADDR_W   = 5,
  parameter int          NUM_REGS = 32,
  parameter int          ZERO_REG = 31,
  parameter logic [10:0] MOVK_OP  = 11'b11110010100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                reg2loc,
  input  logic                reg_write,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   read_sel1,
  output logic [ADDR_W-1:0]   read_sel2,
  output logic [ADDR_W-1:0]   write_sel,
  output logic                write_en,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_sel,
  input  logic                flush,
  output logic [NUM_REGS-1:0] pending,
  output logic                stall
);
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              wen;
  } sel_t;

  sel_t                dec, sel_d, sel_q;
  logic                out_valid_d, out_valid_q;
  logic                hz, accept;
  logic [NUM_REGS-1:0] pend_vec, pend_eff, clr_vec, set_vec;
  logic                unused_bits;

  assign unused_bits = ^instruction[15:10];

  always_comb begin
    dec.rs1 = (instruction[INSTR_W-1 -: 11] == MOVK_OP) ? instruction[ADDR_W-1:0]
                                                        : instruction[5 +: ADDR_W];
    dec.rs2 = reg2loc ? instruction[ADDR_W-1:0] : instruction[16 +: ADDR_W];
    dec.rd  = instruction[ADDR_W-1:0];
    dec.wen = reg_write & (instruction[ADDR_W-1:0] != ZR);
  end

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : g_sb
      assign clr_vec[i]  = wb_valid & (wb_sel == ADDR_W'(i));
      assign set_vec[i]  = accept & dec.wen & (dec.rd == ADDR_W'(i));
      assign pend_eff[i] = pend_vec[i] & ~clr_vec[i];
      reg_select_scoreboard_entry u_ent (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (set_vec[i]),
        .clr   (clr_vec[i]),
        .flush (flush),
        .pend  (pend_vec[i])
      );
    end
  endgenerate

  // ZERO_REG is never pending, but it is masked anyway so a stray retire cannot matter.
  assign hz = (pend_eff[dec.rs1] & (dec.rs1 != ZR))
            | (pend_eff[dec.rs2] & (dec.rs2 != ZR))
            | (reg_write & (dec.rd != ZR) & pend_eff[dec.rd]);

  assign in_ready = ~flush & ~hz & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign stall    = in_valid & ~in_ready;

  always_comb begin
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      sel_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign read_sel1 = sel_q.rs1;
  assign read_sel2 = sel_q.rs2;
  assign write_sel = sel_q.rd;
  assign write_en  = sel_q.wen;
  assign pending   = pend_vec;
endmodule
